mdu_unit: RTL and testbench

- Multi-cycle multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. Owns the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO. MFHI/MFLO read HI/LO through the HiE/LoE outputs.
- Drives MDUReadyE to the hazard unit, which stalls IF/ID/EX and flushes MEM while MDUReadyE is low.
- HI/LO commit only when the instruction leaves EX, so an exception in MEM cleanly kills a younger MDU op.

---
 rtl/mdu_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_mdu_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// -----------------------------------------------------------------------------
// mdu_unit
//   Multi-cycle multiply/divide unit in the EX stage of the 5-stage MIPS
//   pipeline. Owns the architectural HI/LO registers and executes
//   MULT/MULTU/DIV/DIVU/MTHI/MTLO. HI/LO are only written when the
//   instruction leaves EX (StallE=0, FlushE=0), so a younger MDU op can be
//   killed cleanly by an exception in MEM.
//
// Parameters
//   MUL_CYCLES  cycles MDUReadyE stays low for MULT/MULTU (1..8)
//
// Ports
//   clk        pipeline clock
//   resetn     asynchronous active-low reset
//   MDUOpE     op in EX: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU,
//              101 MTHI, 110 MTLO, 111 none
//   SrcAE      forwarded rs (dividend / multiplicand / MTHI-MTLO data)
//   SrcBE      forwarded rt (divisor / multiplier)
//   StallE     EX held this cycle
//   FlushE     instruction in EX is being killed
//   MDUReadyE  low while the op in EX is still computing
//   HiE, LoE   current HI / LO
//   BusyE      FSM not idle
// -----------------------------------------------------------------------------
module mdu_unit #(
   parameter int unsigned MUL_CYCLES = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [2:0]  MDUOpE,
   input  logic [31:0] SrcAE,
   input  logic [31:0] SrcBE,
   input  logic        StallE,
   input  logic        FlushE,
   output logic        MDUReadyE,
   output logic [31:0] HiE,
   output logic [31:0] LoE,
   output logic        BusyE
);

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   localparam logic [4:0] MUL_CNT_INIT = 5'(MUL_CYCLES - 1);
   localparam logic [4:0] DIV_LAST     = 5'd31;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   state_t      state_q,   state_d;
   logic [4:0]  cnt_q,     cnt_d;
   logic        is_div_q,  is_div_d;
   logic        q_neg_q,   q_neg_d;
   logic        r_neg_q,   r_neg_d;
   logic [31:0] divisor_q, divisor_d;
   // Shared result register: {HI, LO} product for multiplies,
   // {partial remainder, dividend/quotient shift register} for divides.
   logic [63:0] res_q,     res_d;
   logic [31:0] hi_q,      hi_d;
   logic [31:0] lo_q,      lo_d;

   // ---------------------------------------------------------------------
   // Datapath helpers
   // ---------------------------------------------------------------------
   logic        mult_signed;
   logic        div_signed;
   logic [63:0] mul_a_ext;
   logic [63:0] mul_b_ext;
   logic [63:0] product;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [32:0] rem_shift;
   logic [32:0] rem_diff;
   logic [63:0] div_step;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;
   logic [63:0] commit_val;

   assign mult_signed = (MDUOpE == OP_MULT);
   assign div_signed  = (MDUOpE == OP_DIV);

   // Sign- or zero-extend to 64 bits; the low 64 bits of the unsigned
   // product are then the correct signed or unsigned 32x32 result.
   assign mul_a_ext = {{32{mult_signed & SrcAE[31]}}, SrcAE};
   assign mul_b_ext = {{32{mult_signed & SrcBE[31]}}, SrcBE};
   assign product   = mul_a_ext * mul_b_ext;

   assign a_mag = (div_signed && SrcAE[31]) ? (-SrcAE) : SrcAE;
   assign b_mag = (div_signed && SrcBE[31]) ? (-SrcBE) : SrcBE;

   // One restoring step: shift the next dividend bit into the remainder and
   // subtract the divisor; bit 32 of the difference is the borrow. A zero
   // divisor never borrows, giving quotient all-ones and remainder = dividend.
   assign rem_shift = {res_q[63:32], res_q[31]};
   assign rem_diff  = rem_shift - {1'b0, divisor_q};
   assign div_step  = rem_diff[32] ? {rem_shift[31:0], res_q[30:0], 1'b0}
                                   : {rem_diff[31:0],  res_q[30:0], 1'b1};

   // Sign fix-up: quotient negative when operand signs differ, remainder
   // follows the dividend.
   assign quo_fix    = q_neg_q ? (-res_q[31:0])  : res_q[31:0];
   assign rem_fix    = r_neg_q ? (-res_q[63:32]) : res_q[63:32];
   assign commit_val = is_div_q ? {rem_fix, quo_fix} : res_q;

   // ---------------------------------------------------------------------
   // Next-state / output logic
   // ---------------------------------------------------------------------
   // NOTE: every variable gets a default before the case statement so that
   // no path leaves one unassigned, which would infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      q_neg_d   = q_neg_q;
      r_neg_d   = r_neg_q;
      divisor_d = divisor_q;
      res_d     = res_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      MDUReadyE = 1'b1;

      case (state_q)
         ST_IDLE: begin
            case (MDUOpE)
               OP_MULT, OP_MULTU: begin
                  // Product captured at launch; the MUL state models the
                  // remaining multiplier latency.
                  MDUReadyE = 1'b0;
                  is_div_d  = 1'b0;
                  res_d     = product;
                  cnt_d     = MUL_CNT_INIT;
                  state_d   = (MUL_CYCLES <= 1) ? ST_DONE : ST_MUL;
               end
               OP_DIV, OP_DIVU: begin
                  MDUReadyE = 1'b0;
                  is_div_d  = 1'b1;
                  divisor_d = b_mag;
                  res_d     = {32'd0, a_mag};
                  q_neg_d   = div_signed & (SrcAE[31] ^ SrcBE[31]);
                  r_neg_d   = div_signed & SrcAE[31];
                  cnt_d     = 5'd0;
                  state_d   = ST_DIV;
               end
               OP_MTHI: begin
                  if (!StallE) hi_d = SrcAE;
               end
               OP_MTLO: begin
                  if (!StallE) lo_d = SrcAE;
               end
               default: ;
            endcase
         end

         ST_MUL: begin
            MDUReadyE = 1'b0;
            cnt_d     = cnt_q - 5'd1;
            if (cnt_q == 5'd1) state_d = ST_DONE;
         end

         ST_DIV: begin
            MDUReadyE = 1'b0;
            res_d     = div_step;
            cnt_d     = cnt_q + 5'd1;
            if (cnt_q == DIV_LAST) state_d = ST_DONE;
         end

         ST_DONE: begin
            // Result is held here until EX actually advances.
            if (!StallE) begin
               hi_d    = commit_val[63:32];
               lo_d    = commit_val[31:0];
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // A kill overrides everything: release the stall so the flush can
      // proceed, drop any partial result and never touch HI/LO.
      if (FlushE) begin
         MDUReadyE = 1'b1;
         state_d   = ST_IDLE;
         hi_d      = hi_q;
         lo_d      = lo_q;
      end
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its pre-edge value regardless of statement order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 5'd0;
         is_div_q  <= 1'b0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         divisor_q <= 32'd0;
         res_q     <= 64'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         q_neg_q   <= q_neg_d;
         r_neg_q   <= r_neg_d;
         divisor_q <= divisor_d;
         res_q     <= res_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign HiE   = hi_q;
   assign LoE   = lo_q;
   assign BusyE = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mdu_unit.sv
// -----------------------------------------------------------------------------
// tb_mdu_unit
//   Self-checking bench for mdu_unit. A table of operations with expected
//   HI/LO and ready-low latency is applied in order; expectations go into a
//   scoreboard queue when an op is issued and are popped once the op has
//   left EX. Hand-written sequences cover flush, MemStall in DONE, MTLO->MFLO
//   and reset mid-operation.
// -----------------------------------------------------------------------------
module tb_mdu_unit;

   localparam int MUL_CYCLES = 2;
   localparam int DIV_LAT    = 33;
   localparam int WAIT_LIMIT = 200;

   localparam logic [2:0] OP_NONE  = 3'b000;
   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } exp_t;

   logic        clk;
   logic        resetn;
   logic [2:0]  mdu_op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        mem_stall;
   logic        flush;
   logic        stall_e;
   logic        mdu_ready;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;

   int errors = 0;
   int checks = 0;

   exp_t sb_q[$];
   vec_t vecs[16];

   // Hazard unit: EX stalls on MemStall or while the MDU is computing.
   assign stall_e = mem_stall | ~mdu_ready;

   mdu_unit #(.MUL_CYCLES(MUL_CYCLES)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .MDUOpE    (mdu_op),
      .SrcAE     (src_a),
      .SrcBE     (src_b),
      .StallE    (stall_e),
      .FlushE    (flush),
      .MDUReadyE (mdu_ready),
      .HiE       (hi),
      .LoE       (lo),
      .BusyE     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Issue one op into EX and keep it there until it leaves (ready and not
   // stalled at a rising edge). Returns the number of cycles ready was low.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int low_cycles);
      int guard;
      @(negedge clk);
      mdu_op = op;
      src_a  = a;
      src_b  = b;
      low_cycles = 0;
      guard = 0;
      #1;
      while (!(mdu_ready && !stall_e) && guard < WAIT_LIMIT) begin
         if (!mdu_ready) low_cycles++;
         @(negedge clk);
         #1;
         guard++;
      end
      check("no_timeout", {31'd0, (guard >= WAIT_LIMIT)}, 32'd0);
      // The next rising edge retires the op; replace it with a bubble.
      @(negedge clk);
      mdu_op = OP_NONE;
      src_a  = 32'd0;
      src_b  = 32'd0;
      #1;
   endtask

   initial begin
      int   lat;
      exp_t e;

      // name, op, a, b, expected hi, expected lo, ready-low cycles
      vecs[0]  = '{"mult_neg2x3",   OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MUL_CYCLES};
      vecs[1]  = '{"multu_max",     OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_CYCLES};
      vecs[2]  = '{"mult_minsq",    OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MUL_CYCLES};
      vecs[3]  = '{"multu_2p32",    OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, MUL_CYCLES};
      vecs[4]  = '{"divu_100_7",    OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       DIV_LAT};
      vecs[5]  = '{"div_m7_2",      OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT};
      vecs[6]  = '{"div_7_m2",      OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_LAT};
      vecs[7]  = '{"div_m7_m2",     OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, DIV_LAT};
      vecs[8]  = '{"divu_5_0",      OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, DIV_LAT};
      vecs[9]  = '{"divu_max_1",    OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, DIV_LAT};
      vecs[10] = '{"divu_3_10",     OP_DIVU,  32'd3,        32'd10,       32'd3,        32'd0,        DIV_LAT};
      vecs[11] = '{"mthi",          OP_MTHI,  32'hCAFEF00D, 32'd0,        32'hCAFEF00D, 32'd0,        0};
      vecs[12] = '{"mtlo",          OP_MTLO,  32'h00001234, 32'd0,        32'hCAFEF00D, 32'h00001234, 0};
      vecs[13] = '{"mult_7_m5",     OP_MULT,  32'd7,        32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD, MUL_CYCLES};
      vecs[14] = '{"div_min_2",     OP_DIV,   32'h80000000, 32'd2,        32'h00000000, 32'hC0000000, DIV_LAT};
      vecs[15] = '{"div_m5_0",      OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'h00000001, DIV_LAT};

      resetn    = 1'b1;
      mdu_op    = OP_NONE;
      src_a     = 32'd0;
      src_b     = 32'd0;
      mem_stall = 1'b0;
      flush     = 1'b0;
      #2 resetn = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_ready", {31'd0, mdu_ready}, 32'd1);
      check("rst_busy",  {31'd0, busy},      32'd0);
      check("rst_hi",    hi, 32'd0);
      check("rst_lo",    lo, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      #1;
      check("post_rst_busy", {31'd0, busy}, 32'd0);

      // Table-driven ops through the scoreboard
      for (int i = 0; i < 16; i++) begin
         sb_q.push_back('{vecs[i].name, vecs[i].hi, vecs[i].lo, vecs[i].lat});
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         e = sb_q.pop_front();
         check({e.name, "_hi"},   hi, e.hi);
         check({e.name, "_lo"},   lo, e.lo);
         check({e.name, "_lat"},  lat, e.lat);
         check({e.name, "_busy"}, {31'd0, busy}, 32'd0);
      end
      // HI/LO now FFFFFFFB / 00000001

      // Flush a DIVU at cycle 10 of its execution
      @(negedge clk);
      mdu_op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
      #1;
      check("flush_launch_ready", {31'd0, mdu_ready}, 32'd0);
      for (int k = 1; k < 10; k++) @(negedge clk);
      flush = 1'b1;
      #1;
      check("flush_ready", {31'd0, mdu_ready}, 32'd1);
      check("flush_busy_before", {31'd0, busy}, 32'd1);
      @(negedge clk);
      flush = 1'b0; mdu_op = OP_NONE; src_a = 32'd0; src_b = 32'd0;
      #1;
      check("flush_idle", {31'd0, busy}, 32'd0);
      check("flush_hi", hi, 32'hFFFFFFFB);
      check("flush_lo", lo, 32'h00000001);
      repeat (40) @(negedge clk);
      #1;
      check("flush_late_hi", hi, 32'hFFFFFFFB);
      check("flush_late_lo", lo, 32'h00000001);

      // Flush in IDLE blocks a launch
      @(negedge clk);
      mdu_op = OP_MULT; src_a = 32'd3; src_b = 32'd4; flush = 1'b1;
      #1;
      check("idle_flush_ready", {31'd0, mdu_ready}, 32'd1);
      @(negedge clk);
      #1;
      check("idle_flush_busy", {31'd0, busy}, 32'd0);
      mdu_op = OP_NONE; flush = 1'b0; src_a = 32'd0; src_b = 32'd0;
      @(negedge clk);
      #1;
      check("idle_flush_lo", lo, 32'h00000001);

      // MULT completes while MemStall holds it in DONE for 4 cycles
      begin
         int low;
         int guard;
         @(negedge clk);
         mdu_op = OP_MULT; src_a = 32'd6; src_b = 32'd7;
         low = 0; guard = 0;
         #1;
         while (!mdu_ready && guard < WAIT_LIMIT) begin
            low++;
            @(negedge clk);
            #1;
            guard++;
         end
         check("stall_mul_lat", low, MUL_CYCLES);
         mem_stall = 1'b1;
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("stall_hold_hi",    hi, 32'hFFFFFFFB);
            check("stall_hold_lo",    lo, 32'h00000001);
            check("stall_hold_busy",  {31'd0, busy}, 32'd1);
            check("stall_hold_ready", {31'd0, mdu_ready}, 32'd1);
         end
         mem_stall = 1'b0;
         @(negedge clk);
         mdu_op = OP_NONE; src_a = 32'd0; src_b = 32'd0;
         #1;
         check("stall_commit_hi",   hi, 32'd0);
         check("stall_commit_lo",   lo, 32'd42);
         check("stall_commit_busy", {31'd0, busy}, 32'd0);
         repeat (3) @(negedge clk);
         #1;
         check("stall_after_lo", lo, 32'd42);
      end

      // MTLO followed directly by MFLO
      @(negedge clk);
      mdu_op = OP_MTLO; src_a = 32'h00001234; src_b = 32'd0;
      #1;
      check("mtlo_ready", {31'd0, mdu_ready}, 32'd1);
      check("mtlo_lo_old", lo, 32'd42);
      @(negedge clk);
      mdu_op = OP_NONE; src_a = 32'd0;
      #1;
      check("mflo_lo", lo, 32'h00001234);
      check("mflo_ready", {31'd0, mdu_ready}, 32'd1);

      // Reset in the middle of a DIV
      @(negedge clk);
      mdu_op = OP_DIV; src_a = 32'd9; src_b = 32'd2;
      repeat (5) @(negedge clk);
      resetn = 1'b0;
      mdu_op = OP_NONE; src_a = 32'd0; src_b = 32'd0;
      #1;
      check("midrst_busy",  {31'd0, busy}, 32'd0);
      check("midrst_ready", {31'd0, mdu_ready}, 32'd1);
      check("midrst_lo",    lo, 32'd0);
      check("midrst_hi",    hi, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      repeat (40) @(negedge clk);
      #1;
      check("midrst_after_lo",   lo, 32'd0);
      check("midrst_after_busy", {31'd0, busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
